// File: rtl/reg_file_32x32.sv
// Three-read/one-write register file with hardwired-zero r0 and synchronous clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int N_PORTS = 3;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr [N_PORTS];
    logic [DATA_W-1:0] rd_data [N_PORTS];

    // A write to address 0 is dropped so entry 0 stays at its reset value of zero.
    assign wr_en = RegWrite && !rst && (WriteReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteReg] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_addr[0] = ReadReg1;
    assign rd_addr[1] = ReadReg2;
    assign rd_addr[2] = DbgReg;

    // Zero check comes last so it overrides both the array and any forwarded data.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rd_addr[p] == WriteReg)) begin
                rd_data[p] = WriteData;
            end
`endif
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign DbgData   = rd_data[2];

endmodule
